// File: rtl/pipe_mem_pkg.sv
// Shared types and constants for the pipeline memory arbiter.
package pipe_mem_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  // Arbiter FSM: every transfer starts from and returns to StIdle.
  typedef enum logic [1:0] {
    StIdle,
    StDataReq,
    StFetchReq,
    StRdResp
  } state_e;

  // Avalon opcode classes; only the upper three bits identify the class.
  localparam logic [5:0] OpLoad  = 6'b100000;
  localparam logic [5:0] OpStore = 6'b101000;
  localparam logic [5:0] OpMask  = 6'b111000;

  localparam be_t BeFull = 4'b1111;
  localparam be_t BeNone = 4'b0000;

  function automatic logic op_is_load(logic [5:0] op);
    return (op & OpMask) == OpLoad;
  endfunction

  function automatic logic op_is_store(logic [5:0] op);
    return (op & OpMask) == OpStore;
  endfunction

  // A data request with no lanes enabled cannot be issued on the bus.
  function automatic logic be_misaligned(be_t be);
    return be == BeNone;
  endfunction

endpackage

// File: rtl/pipe_mem_arbiter_if.sv
// Pipeline request/response lines plus the Avalon master bus of the arbiter.
interface pipe_mem_arbiter_if;
  import pipe_mem_pkg::*;

  // Instruction fetch side
  logic  if_req;
  word_t if_addr;
  word_t if_rdata;
  logic  if_valid;

  // Data (memory-interface stage) side
  logic  dm_read;
  logic  dm_write;
  word_t dm_addr;
  be_t   dm_byteenable;
  word_t dm_wdata;
  word_t dm_rdata;
  logic  dm_valid;
  logic  dm_err;

  logic  FetchMemSel;
  logic  stall;

  // Avalon master bus
  word_t address;
  logic  read;
  logic  write;
  be_t   byteenable;
  word_t writedata;
  word_t readdata;
  logic  waitrequest;

  // Arbiter view
  modport master (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_byteenable, dm_wdata,
    input  readdata, waitrequest,
    output if_rdata, if_valid, dm_rdata, dm_valid, dm_err, FetchMemSel, stall,
    output address, read, write, byteenable, writedata
  );

  // Pipeline and memory view
  modport slave (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_byteenable, dm_wdata,
    output readdata, waitrequest,
    input  if_rdata, if_valid, dm_rdata, dm_valid, dm_err, FetchMemSel, stall,
    input  address, read, write, byteenable, writedata
  );

endinterface

// File: rtl/pipe_rdata_reg.sv
// Read-data holding register: loads on a capture strobe, otherwise holds.
module pipe_rdata_reg
  import pipe_mem_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  cap_i,
  input  word_t data_i,
  output word_t q_o
);

  word_t q_q;

  // Capture returned data only when the owning requester's read is accepted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (cap_i) begin
      q_q <= data_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one Avalon master bus.
// Data wins over a simultaneous fetch; each transfer returns through StIdle.
module pipe_mem_arbiter
  import pipe_mem_pkg::*;
(
  input logic                clk,
  input logic                reset,
  pipe_mem_arbiter_if.master pipe_io
);

  state_e state_q, state_d;
  word_t  address_q, address_d;
  word_t  wdata_q, wdata_d;
  be_t    be_q, be_d;
  logic   read_q, read_d;
  logic   write_q, write_d;
  logic   fetch_sel_q, fetch_sel_d;
  logic   if_valid_q, if_valid_d;
  logic   dm_valid_q, dm_valid_d;
  logic   dm_err_q, dm_err_d;
  logic   rw_err_q, rw_err_d;
  logic   cap_if, cap_dm;
  logic   dm_pend, if_pend, accept;
  word_t  if_rdata, dm_rdata;

  // A requester still holds its lines during its valid cycle; mask it there
  assign dm_pend = (pipe_io.dm_read | pipe_io.dm_write) & ~dm_valid_q;
  assign if_pend = pipe_io.if_req & ~if_valid_q;
  assign accept  = (read_q | write_q) & ~pipe_io.waitrequest;

  // State and bus command registers; reset clears read/write without a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      address_q   <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      fetch_sel_q <= 1'b1;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      dm_err_q    <= 1'b0;
      rw_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      read_q      <= read_d;
      write_q     <= write_d;
      fetch_sel_q <= fetch_sel_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      dm_err_q    <= dm_err_d;
      rw_err_q    <= rw_err_d;
    end
  end

  // Next state, bus command and completion strobes
  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    read_d      = read_q;
    write_d     = write_q;
    fetch_sel_d = fetch_sel_q;
    rw_err_d    = rw_err_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    dm_err_d    = 1'b0;
    cap_if      = 1'b0;
    cap_dm      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dm_pend) begin
          if (be_misaligned(pipe_io.dm_byteenable)) begin
            // No bus cycle: complete with an error straight from idle
            dm_valid_d = 1'b1;
            dm_err_d   = 1'b1;
          end else begin
            state_d     = StDataReq;
            address_d   = pipe_io.dm_addr;
            be_d        = pipe_io.dm_byteenable;
            wdata_d     = pipe_io.dm_wdata;
            read_d      = pipe_io.dm_read;
            // Read+write together is issued as a read and flagged on completion
            write_d     = pipe_io.dm_write & ~pipe_io.dm_read;
            rw_err_d    = pipe_io.dm_read & pipe_io.dm_write;
            fetch_sel_d = 1'b0;
          end
        end else if (if_pend) begin
          state_d     = StFetchReq;
          address_d   = pipe_io.if_addr;
          be_d        = BeFull;
          read_d      = 1'b1;
          write_d     = 1'b0;
          rw_err_d    = 1'b0;
          fetch_sel_d = 1'b1;
        end
      end

      StDataReq: begin
        if (accept) begin
          read_d     = 1'b0;
          write_d    = 1'b0;
          dm_valid_d = 1'b1;
          if (read_q) begin
            cap_dm   = 1'b1;
            dm_err_d = rw_err_q;
            state_d  = StRdResp;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StFetchReq: begin
        if (accept) begin
          read_d     = 1'b0;
          cap_if     = 1'b1;
          if_valid_d = 1'b1;
          state_d    = StRdResp;
        end
      end

      StRdResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  pipe_rdata_reg u_if_rdata (
    .clk_i  (clk),
    .rst_i  (reset),
    .cap_i  (cap_if),
    .data_i (pipe_io.readdata),
    .q_o    (if_rdata)
  );

  pipe_rdata_reg u_dm_rdata (
    .clk_i  (clk),
    .rst_i  (reset),
    .cap_i  (cap_dm),
    .data_i (pipe_io.readdata),
    .q_o    (dm_rdata)
  );

  assign pipe_io.address     = address_q;
  assign pipe_io.read        = read_q;
  assign pipe_io.write       = write_q;
  assign pipe_io.byteenable  = be_q;
  assign pipe_io.writedata   = wdata_q;
  assign pipe_io.FetchMemSel = fetch_sel_q;
  assign pipe_io.if_valid    = if_valid_q;
  assign pipe_io.dm_valid    = dm_valid_q;
  assign pipe_io.dm_err      = dm_err_q;
  assign pipe_io.if_rdata    = if_rdata;
  assign pipe_io.dm_rdata    = dm_rdata;
  assign pipe_io.stall       = if_pend | dm_pend;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level timing/data model.
module tb_pipe_mem_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        fsel;
  } xfer_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  pipe_mem_arbiter_if pif ();

  pipe_mem_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .pipe_io (pif)
  );

  always #5 clk = ~clk;

  // Memory agent: wait states per transfer and constant read data
  int unsigned wait_target = 0;
  int unsigned wait_cnt = 0;
  logic [31:0] rd_value = 32'h0;
  xfer_t       acc_q[$];
  int          if_valid_cnt = 0;
  int          dm_valid_cnt = 0;
  logic [31:0] exp_if_rdata = 32'h0;
  logic [31:0] exp_dm_rdata = 32'h0;

  assign pif.readdata = rd_value;

  always @(posedge clk) begin
    #1;
    if (!(pif.read || pif.write)) begin
      wait_cnt = 0;
      pif.waitrequest = 1'b0;
    end else if (wait_cnt < wait_target) begin
      wait_cnt++;
      pif.waitrequest = 1'b1;
    end else begin
      pif.waitrequest = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset !== 1'b1 && (pif.read || pif.write) && pif.waitrequest === 1'b0)
      acc_q.push_back('{pif.address, pif.read, pif.write, pif.byteenable, pif.writedata,
                        pif.FetchMemSel});
    if (pif.if_valid === 1'b1) if_valid_cnt++;
    if (pif.dm_valid === 1'b1) dm_valid_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (pif.read !== 1'b0) begin failures++; $display("FAIL rst_read got=%b exp=0", pif.read); end
    checks++; if (pif.write !== 1'b0) begin failures++; $display("FAIL rst_write got=%b exp=0", pif.write); end
    checks++; if (pif.address !== 32'h0) begin failures++; $display("FAIL rst_address got=%h exp=0", pif.address); end
    checks++; if (pif.byteenable !== 4'h0) begin failures++; $display("FAIL rst_be got=%h exp=0", pif.byteenable); end
    checks++; if (pif.writedata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", pif.writedata); end
    checks++; if (pif.FetchMemSel !== 1'b1) begin failures++; $display("FAIL rst_fsel got=%b exp=1", pif.FetchMemSel); end
    checks++; if ({pif.if_valid, pif.dm_valid, pif.dm_err} !== 3'b000) begin failures++; $display("FAIL rst_strobes got=%b exp=000", {pif.if_valid, pif.dm_valid, pif.dm_err}); end
    checks++; if (pif.if_rdata !== 32'h0 || pif.dm_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0/0", pif.if_rdata, pif.dm_rdata); end
    checks++; if (pif.stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", pif.stall); end
    tick();
  endtask

  task automatic test_fetch_basic();
    wait_target = 0;
    rd_value = 32'hDEAD_BEEF;
    pif.if_req = 1'b1;
    pif.if_addr = 32'h100;
    @(negedge clk);
    checks++; if (pif.stall !== 1'b1) begin failures++; $display("FAIL fetch_c0_stall got=%b exp=1", pif.stall); end
    tick();
    @(negedge clk);
    checks++; if (pif.read !== 1'b1 || pif.address !== 32'h100) begin failures++; $display("FAIL fetch_c1_cmd got=%b/%h exp=1/00000100", pif.read, pif.address); end
    checks++; if (pif.byteenable !== 4'hF || pif.FetchMemSel !== 1'b1) begin failures++; $display("FAIL fetch_c1_be_sel got=%h/%b exp=f/1", pif.byteenable, pif.FetchMemSel); end
    checks++; if (pif.if_valid !== 1'b0) begin failures++; $display("FAIL fetch_c1_valid got=%b exp=0", pif.if_valid); end
    tick();
    @(negedge clk);
    checks++; if (pif.if_valid !== 1'b1) begin failures++; $display("FAIL fetch_c2_valid got=%b exp=1", pif.if_valid); end
    checks++; if (pif.if_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fetch_c2_rdata got=%h exp=deadbeef", pif.if_rdata); end
    checks++; if (pif.stall !== 1'b0) begin failures++; $display("FAIL fetch_c2_stall got=%b exp=0", pif.stall); end
    exp_if_rdata = 32'hDEAD_BEEF;
    tick();
    pif.if_req = 1'b0;
    @(negedge clk);
    checks++; if (pif.if_valid !== 1'b0 || pif.read !== 1'b0) begin failures++; $display("FAIL fetch_c3_idle got=%b/%b exp=0/0", pif.if_valid, pif.read); end
    tick();
  endtask

  task automatic test_priority();
    wait_target = 0;
    rd_value = 32'hCAFE_0001;
    pif.dm_write = 1'b1;
    pif.dm_addr = 32'h200;
    pif.dm_byteenable = 4'b0011;
    pif.dm_wdata = 32'h1234;
    pif.if_req = 1'b1;
    pif.if_addr = 32'h300;
    tick();
    @(negedge clk);
    checks++; if (pif.write !== 1'b1 || pif.read !== 1'b0) begin failures++; $display("FAIL prio_c1_cmd got=w%b r%b exp=w1 r0", pif.write, pif.read); end
    checks++; if (pif.address !== 32'h200 || pif.byteenable !== 4'b0011) begin failures++; $display("FAIL prio_c1_addr got=%h/%h exp=00000200/3", pif.address, pif.byteenable); end
    checks++; if (pif.writedata !== 32'h1234 || pif.FetchMemSel !== 1'b0) begin failures++; $display("FAIL prio_c1_wdata got=%h/%b exp=00001234/0", pif.writedata, pif.FetchMemSel); end
    tick();
    @(negedge clk);
    checks++; if (pif.dm_valid !== 1'b1 || pif.dm_err !== 1'b0) begin failures++; $display("FAIL prio_c2_dm got=%b/%b exp=1/0", pif.dm_valid, pif.dm_err); end
    checks++; if (pif.read !== 1'b0 || pif.write !== 1'b0) begin failures++; $display("FAIL prio_c2_idle got=r%b w%b exp=r0 w0", pif.read, pif.write); end
    checks++; if (pif.dm_rdata !== exp_dm_rdata) begin failures++; $display("FAIL prio_c2_rdata got=%h exp=%h", pif.dm_rdata, exp_dm_rdata); end
    tick();
    pif.dm_write = 1'b0;
    @(negedge clk);
    checks++; if (pif.read !== 1'b1 || pif.address !== 32'h300 || pif.FetchMemSel !== 1'b1) begin failures++; $display("FAIL prio_c3_fetch got=%b/%h/%b exp=1/00000300/1", pif.read, pif.address, pif.FetchMemSel); end
    checks++; if (pif.dm_valid !== 1'b0) begin failures++; $display("FAIL prio_c3_dmvalid got=%b exp=0", pif.dm_valid); end
    tick();
    @(negedge clk);
    checks++; if (pif.if_valid !== 1'b1 || pif.if_rdata !== 32'hCAFE_0001) begin failures++; $display("FAIL prio_c4_fetch got=%b/%h exp=1/cafe0001", pif.if_valid, pif.if_rdata); end
    exp_if_rdata = 32'hCAFE_0001;
    tick();
    pif.if_req = 1'b0;
    @(negedge clk);
    tick();
  endtask

  task automatic test_wait_hold();
    int base;
    base = dm_valid_cnt;
    wait_target = 3;
    rd_value = $urandom;
    pif.dm_read = 1'b1;
    pif.dm_addr = 32'h44;
    pif.dm_byteenable = 4'b0101;
    for (int c = 1; c <= 4; c++) begin
      tick();
      @(negedge clk);
      checks++; if (pif.read !== 1'b1 || pif.address !== 32'h44 || pif.byteenable !== 4'b0101) begin failures++; $display("FAIL wait_hold_c%0d got=%b/%h/%h exp=1/00000044/5", c, pif.read, pif.address, pif.byteenable); end
      checks++; if (pif.dm_valid !== 1'b0) begin failures++; $display("FAIL wait_early_valid_c%0d got=%b exp=0", c, pif.dm_valid); end
    end
    tick();
    @(negedge clk);
    checks++; if (pif.dm_valid !== 1'b1 || pif.dm_err !== 1'b0) begin failures++; $display("FAIL wait_c5_valid got=%b/%b exp=1/0", pif.dm_valid, pif.dm_err); end
    checks++; if (pif.dm_rdata !== rd_value) begin failures++; $display("FAIL wait_c5_rdata got=%h exp=%h", pif.dm_rdata, rd_value); end
    exp_dm_rdata = rd_value;
    tick();
    pif.dm_read = 1'b0;
    repeat (3) tick();
    checks++; if (dm_valid_cnt - base !== 1) begin failures++; $display("FAIL wait_pulses got=%0d exp=1", dm_valid_cnt - base); end
    wait_target = 0;
  endtask

  task automatic test_misaligned();
    int base_acc;
    base_acc = acc_q.size();
    pif.dm_write = 1'b1;
    pif.dm_addr = 32'h208;
    pif.dm_byteenable = 4'b0000;
    pif.dm_wdata = 32'h5555_AAAA;
    @(negedge clk);
    checks++; if (pif.write !== 1'b0) begin failures++; $display("FAIL mis_c0_write got=%b exp=0", pif.write); end
    tick();
    @(negedge clk);
    checks++; if (pif.dm_valid !== 1'b1 || pif.dm_err !== 1'b1) begin failures++; $display("FAIL mis_c1_strobes got=%b/%b exp=1/1", pif.dm_valid, pif.dm_err); end
    checks++; if (pif.write !== 1'b0) begin failures++; $display("FAIL mis_c1_write got=%b exp=0", pif.write); end
    tick();
    pif.dm_write = 1'b0;
    @(negedge clk);
    checks++; if (pif.dm_valid !== 1'b0 || pif.dm_err !== 1'b0 || pif.write !== 1'b0) begin failures++; $display("FAIL mis_c2_idle got=%b/%b/%b exp=0/0/0", pif.dm_valid, pif.dm_err, pif.write); end
    tick();
    checks++; if (acc_q.size() !== base_acc) begin failures++; $display("FAIL mis_bus_cycles got=%0d exp=0", acc_q.size() - base_acc); end
  endtask

  task automatic test_reset_mid();
    int base_if;
    base_if = if_valid_cnt;
    wait_target = 100;
    pif.if_req = 1'b1;
    pif.if_addr = 32'h500;
    tick();
    @(negedge clk);
    checks++; if (pif.read !== 1'b1) begin failures++; $display("FAIL rmid_read_before got=%b exp=1", pif.read); end
    #1 reset = 1'b1;
    #1;
    checks++; if (pif.read !== 1'b0 || pif.write !== 1'b0) begin failures++; $display("FAIL rmid_async got=r%b w%b exp=r0 w0", pif.read, pif.write); end
    tick();
    pif.if_req = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      checks++; if (pif.if_valid !== 1'b0 || pif.read !== 1'b0) begin failures++; $display("FAIL rmid_after_c%0d got=%b/%b exp=0/0", c, pif.if_valid, pif.read); end
    end
    checks++; if (pif.address !== 32'h0 || pif.FetchMemSel !== 1'b1) begin failures++; $display("FAIL rmid_regs got=%h/%b exp=0/1", pif.address, pif.FetchMemSel); end
    checks++; if (if_valid_cnt !== base_if) begin failures++; $display("FAIL rmid_no_valid got=%0d exp=0", if_valid_cnt - base_if); end
    exp_if_rdata = 32'h0;
    exp_dm_rdata = 32'h0;
    wait_target = 0;
    tick();
  endtask

  task automatic test_random(input int n);
    for (int it = 0; it < n; it++) begin
      int          kind, w, base, dm_at, if_at, dm_exp, if_exp, ne;
      logic        has_fetch, has_data, d_rd, d_wr, misal, conflict, exp_err;
      logic        dm_seen, if_seen, dm_now, if_now, exp_stall;
      logic [31:0] ia, da, wd;
      logic [3:0]  be;
      xfer_t       exp_q[$];
      xfer_t       got;

      kind = $urandom_range(0, 5);
      w = $urandom_range(0, 3);
      ia = $urandom & 32'hFFFF_FFFC;
      da = $urandom & 32'hFFFF_FFFC;
      wd = $urandom;
      be = 4'($urandom_range(1, 15));
      rd_value = $urandom;
      wait_target = w;
      has_fetch = (kind == 0) || (kind == 5);
      has_data = (kind != 0);
      d_rd = 1'b0;
      d_wr = 1'b0;
      misal = 1'b0;
      case (kind)
        1: d_rd = 1'b1;
        2: d_wr = 1'b1;
        3: begin
          misal = 1'b1;
          be = 4'b0000;
          if ($urandom_range(0, 1) == 1) d_rd = 1'b1; else d_wr = 1'b1;
        end
        4: begin d_rd = 1'b1; d_wr = 1'b1; end
        5: if ($urandom_range(0, 1) == 1) d_rd = 1'b1; else d_wr = 1'b1;
        default: ;
      endcase
      conflict = d_rd && d_wr;
      exp_err = misal || conflict;

      // Model: a bus transfer costs 2+w cycles; a write completes in idle, a read
      // spends its valid cycle in the response phase, so a following fetch
      // starts one cycle later after a read than after a write or an error.
      exp_q.delete();
      dm_exp = misal ? 1 : 2 + w;
      if (!has_data) if_exp = 2 + w;
      else if_exp = ((misal || !d_rd) ? dm_exp : dm_exp + 1) + 2 + w;
      if (has_data && !misal) exp_q.push_back('{da, 1'b1 & d_rd, d_wr & ~d_rd, be, wd, 1'b0});
      if (has_fetch) exp_q.push_back('{ia, 1'b1, 1'b0, 4'hF, 32'h0, 1'b1});

      base = acc_q.size();
      pif.dm_read = d_rd;
      pif.dm_write = d_wr;
      pif.dm_addr = da;
      pif.dm_byteenable = be;
      pif.dm_wdata = wd;
      pif.if_req = has_fetch;
      pif.if_addr = ia;
      dm_seen = !has_data;
      if_seen = !has_fetch;
      dm_at = -1;
      if_at = -1;

      for (int c = 0; c < 40 && !(dm_seen && if_seen); c++) begin
        @(negedge clk);
        dm_now = pif.dm_valid;
        if_now = pif.if_valid;
        exp_stall = (pif.if_req && !if_now) || ((pif.dm_read || pif.dm_write) && !dm_now);
        checks++; if (pif.stall !== exp_stall) begin failures++; $display("FAIL rnd%0d_stall_c%0d got=%b exp=%b", it, c, pif.stall, exp_stall); end
        if (dm_now === 1'b1) begin
          checks++;
          if (dm_seen) begin
            failures++; $display("FAIL rnd%0d_dm_extra c=%0d got=1 exp=0", it, c);
          end else begin
            dm_at = c;
            checks++; if (pif.dm_err !== exp_err) begin failures++; $display("FAIL rnd%0d_dm_err got=%b exp=%b", it, pif.dm_err, exp_err); end
            if (d_rd && !misal) exp_dm_rdata = rd_value;
            if (pif.dm_rdata !== exp_dm_rdata) begin failures++; $display("FAIL rnd%0d_dm_rdata got=%h exp=%h", it, pif.dm_rdata, exp_dm_rdata); end
          end
          dm_seen = 1'b1;
        end
        if (if_now === 1'b1) begin
          checks++;
          if (if_seen) begin
            failures++; $display("FAIL rnd%0d_if_extra c=%0d got=1 exp=0", it, c);
          end else begin
            if_at = c;
            exp_if_rdata = rd_value;
            checks++; if (pif.if_rdata !== exp_if_rdata) begin failures++; $display("FAIL rnd%0d_if_rdata got=%h exp=%h", it, pif.if_rdata, exp_if_rdata); end
          end
          if_seen = 1'b1;
        end
        tick();
        if (dm_now === 1'b1) begin pif.dm_read = 1'b0; pif.dm_write = 1'b0; end
        if (if_now === 1'b1) pif.if_req = 1'b0;
      end

      checks++;
      if (!(dm_seen && if_seen)) begin
        failures++; $display("FAIL rnd%0d_timeout kind=%0d got=dm%b if%b exp=dm1 if1", it, kind, dm_seen, if_seen);
        pif.dm_read = 1'b0; pif.dm_write = 1'b0; pif.if_req = 1'b0;
        repeat (3) tick();
      end
      if (has_data) begin
        checks++; if (dm_at !== dm_exp) begin failures++; $display("FAIL rnd%0d_dm_latency kind=%0d w=%0d got=%0d exp=%0d", it, kind, w, dm_at, dm_exp); end
      end
      if (has_fetch) begin
        checks++; if (if_at !== if_exp) begin failures++; $display("FAIL rnd%0d_if_latency kind=%0d w=%0d got=%0d exp=%0d", it, kind, w, if_at, if_exp); end
      end
      ne = exp_q.size();
      checks++; if (acc_q.size() - base !== ne) begin failures++; $display("FAIL rnd%0d_xfer_count kind=%0d got=%0d exp=%0d", it, kind, acc_q.size() - base, ne); end
      for (int i = 0; i < ne && base + i < acc_q.size(); i++) begin
        got = acc_q[base + i];
        checks++;
        if (got.addr !== exp_q[i].addr || got.rd !== exp_q[i].rd || got.wr !== exp_q[i].wr ||
            got.be !== exp_q[i].be || got.fsel !== exp_q[i].fsel ||
            (exp_q[i].wr && got.wdata !== exp_q[i].wdata)) begin
          failures++;
          $display("FAIL rnd%0d_xfer%0d got=%h/r%b/w%b/%h/%h/s%b exp=%h/r%b/w%b/%h/%h/s%b", it, i,
                   got.addr, got.rd, got.wr, got.be, got.wdata, got.fsel, exp_q[i].addr,
                   exp_q[i].rd, exp_q[i].wr, exp_q[i].be, exp_q[i].wdata, exp_q[i].fsel);
        end
      end
    end
    wait_target = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    pif.if_req = 1'b0;
    pif.if_addr = 32'h0;
    pif.dm_read = 1'b0;
    pif.dm_write = 1'b0;
    pif.dm_addr = 32'h0;
    pif.dm_byteenable = 4'h0;
    pif.dm_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_fetch_basic();
    test_priority();
    test_wait_hold();
    test_misaligned();
    test_reset_mid();
    test_random(60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_mem_arbiter.md
PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port if_req, input, 1 bit: instruction-fetch request, held until if_valid.
REQ-004 SHALL have port if_addr, input, 32 bits: fetch address, word aligned.
REQ-005 SHALL have port dm_read / dm_write, input, 1 bit each: data load/store request from the memory-interface stage, held until dm_valid.
REQ-006 SHALL have ports dm_addr (32, input), dm_byteenable (4, input), dm_wdata (32, input): word-aligned address, lane enables and store data from the memory-interface stage.
REQ-007 SHALL have ports if_rdata / dm_rdata, output, 32 bits each: registered read data returned to the requester.
REQ-008 SHALL have ports if_valid / dm_valid / dm_err, output, 1 bit each: one-cycle completion and error strobes.
REQ-009 SHALL have port FetchMemSel, output, 1 bit: 1 = the bus access in flight is a fetch, 0 = a data access.
REQ-010 SHALL have port stall, output, 1 bit: pipeline freeze while any held request is incomplete.
REQ-011 SHALL have Avalon master ports address (32, out), read (1, out), write (1, out), byteenable (4, out), writedata (32, out), readdata (32, in), waitrequest (1, in).

Function
REQ-012 SHALL implement FSM states IDLE, DATA_REQ, FETCH_REQ, RD_RESP.
REQ-013 IDLE SHALL go to DATA_REQ if dm_read or dm_write is asserted, else to FETCH_REQ if if_req is asserted, else remain in IDLE; data SHALL win over a simultaneous fetch.
REQ-014 In DATA_REQ/FETCH_REQ, address, read, write, byteenable and writedata SHALL be registered values held constant while waitrequest=1.
REQ-015 A transfer SHALL be accepted at the rising edge where read or write is 1 and waitrequest is 0.
REQ-016 An accepted read SHALL go to RD_RESP; in RD_RESP, readdata SHALL be captured into if_rdata or dm_rdata, the matching valid SHALL pulse for 1 cycle, and the FSM SHALL return to IDLE.
REQ-017 An accepted write SHALL pulse dm_valid in the following cycle and return to IDLE; dm_rdata SHALL be left unchanged.
REQ-018 A data request with dm_byteenable=4'b0000 (misaligned) SHALL generate no bus cycle, SHALL pulse dm_valid and dm_err together one cycle later, and SHALL return to IDLE.
REQ-019 Fetches SHALL always drive byteenable=4'b1111 and FetchMemSel=1.
REQ-020 stall SHALL be 1 whenever (if_req or dm_read or dm_write) is asserted and the corresponding valid strobe is not asserted in that cycle.
REQ-021 Minimum read latency from IDLE with waitrequest=0 SHALL be 2 cycles (request cycle, then RD_RESP with the valid strobe), and write latency SHALL be 2 cycles.
REQ-022 Simultaneous dm_read and dm_write SHALL be treated as a read and SHALL assert dm_err with dm_valid.
REQ-023 The FSM SHALL always pass through IDLE between transfers, giving one idle bus cycle.

Reset
REQ-024 Reset SHALL force state=IDLE; read=0; write=0; if_valid=0; dm_valid=0; dm_err=0; FetchMemSel=1; address=0; byteenable=0; writedata=0; if_rdata=0; dm_rdata=0.
REQ-025 Reset asserted mid-transfer SHALL deassert read and write immediately, without waiting for a clock edge, and SHALL discard the transfer with no valid strobe.

Structure
REQ-026 The state enum and the Avalon opcode constants (LOAD 6'b100xxx, STORE 6'b101xxx) SHALL live in a shared package, pipe_mem_pkg.
REQ-027 The block SHALL be a single module with no sub-modules; the captured read-data registers MAY be factored into the sub-module pipe_rdata_reg.

Verification
REQ-028 Bench: if_req=1, if_addr=0x100, waitrequest=0, readdata=0xDEADBEEF -> read=1 and address=0x100 in cycle 1; if_valid=1 and if_rdata=0xDEADBEEF in cycle 2.
REQ-029 Bench: dm_write=1 and if_req=1 asserted together, addr=0x200, be=4'b0011, wdata=0x1234 -> the write is issued first with FetchMemSel=0; dm_valid pulses; the fetch follows after one IDLE cycle.
REQ-030 Bench: dm_read with waitrequest held high for 3 cycles -> address, read and byteenable are stable for all 4 cycles; dm_valid pulses exactly once.
REQ-031 Bench: dm_write with dm_byteenable=0 -> no write pulse on the bus; dm_valid=dm_err=1 for 1 cycle.
REQ-032 Bench: reset asserted during FETCH_REQ with waitrequest=1 -> read=0 in the same cycle; state is IDLE; no if_valid is produced.
